// File: rtl/readout_pkg.sv
// Shared types and helpers for the per-BX readout scheduler.
// Holds FSM state encoding, field widths and a saturating increment.
package readout_pkg;

    localparam int CNT_W    = 6;
    localparam int SUM_W    = 10;
    localparam int BX_W     = 3;
    localparam int CLKCNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic [SUM_W-1:0] sat_inc(
        input logic [SUM_W-1:0] v
    );
        return (&v) ? v : v + SUM_W'(1);
    endfunction

endpackage

// File: rtl/readout_bx_scheduler_item_sum_tree.sv
// item_sum_tree: sums NMEM 6-bit item counts into a 10-bit total.
// Ports: clk, reset (sync, high), load_i (capture), counts_i (packed), sum_o (registered).
module item_sum_tree
    import readout_pkg::*;
#(
    parameter int NMEM = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [NMEM*CNT_W-1:0]   counts_i,
    output logic [SUM_W-1:0]        sum_o
);

    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NMEM; k++) begin
            sum_d = sum_d + SUM_W'(counts_i[k*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (load_i) begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/readout_bx_scheduler.sv
// readout_bx_scheduler: BX timebase, merger start pulse and per-event close/report.
// Ports: clk, reset (sync, high), enable, number_in, valid, none -> start, BX, clk_cnt,
// BX_pipe, busy, bx_done, truncated, mismatch, word_cnt, trunc_cnt, mism_cnt.
// Optional READOUT_STATS_EN: live truncation/mismatch counters (else tied to zero).
module readout_bx_scheduler
    import readout_pkg::*;
#(
    parameter int NMEM      = 12,
    parameter int BX_PERIOD = 100,
    parameter int SETUP_CYC = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NMEM*CNT_W-1:0]   number_in,
    input  logic                    valid,
    input  logic                    none,
    output logic                    start,
    output logic [BX_W-1:0]         BX,
    output logic [CLKCNT_W-1:0]     clk_cnt,
    output logic [BX_W-1:0]         BX_pipe,
    output logic                    busy,
    output logic                    bx_done,
    output logic                    truncated,
    output logic                    mismatch,
    output logic [SUM_W-1:0]        word_cnt,
    output logic [15:0]             trunc_cnt,
    output logic [15:0]             mism_cnt
);

    // Internal timebase runs one cycle ahead of the visible clk_cnt/BX,
    // so the registered start pulse lines up with clk_cnt==0.
    logic [CLKCNT_W-1:0] cnt_q;
    logic [BX_W-1:0]     bx_q;
    logic                start_ev;

    assign start_ev = enable && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            bx_q    <= '0;
            clk_cnt <= '0;
            BX      <= '0;
            start   <= 1'b0;
        end else begin
            if (enable) begin
                if (cnt_q == CLKCNT_W'(BX_PERIOD - 1)) begin
                    cnt_q <= '0;
                    bx_q  <= bx_q + BX_W'(1);
                end else begin
                    cnt_q <= cnt_q + CLKCNT_W'(1);
                end
            end
            clk_cnt <= cnt_q;
            BX      <= bx_q;
            start   <= start_ev;
        end
    end

    logic [SUM_W-1:0] expected;

    item_sum_tree #(
        .NMEM(NMEM)
    ) u_sum (
        .clk      (clk),
        .reset    (reset),
        .load_i   (start_ev),
        .counts_i (number_in),
        .sum_o    (expected)
    );

    state_e           state_q;
    logic [7:0]       setup_q;
    logic [1:0]       flush_q;
    logic [SUM_W-1:0] wc_q;
    logic             clr_q;
    logic [SUM_W-1:0] wc_d;

    // Word count including this cycle's beat; only RUN counts.
    assign wc_d = (state_q == ST_RUN && valid) ? sat_inc(wc_q) : wc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            setup_q   <= '0;
            flush_q   <= '0;
            wc_q      <= '0;
            clr_q     <= 1'b0;
            BX_pipe   <= '0;
            busy      <= 1'b0;
            bx_done   <= 1'b0;
            truncated <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            bx_done   <= 1'b0;
            truncated <= 1'b0;
            mismatch  <= 1'b0;
            clr_q     <= 1'b0;
            if (start_ev) begin
                BX_pipe <= bx_q;
                state_q <= ST_SETUP;
                setup_q <= 8'd1;
                flush_q <= '0;
                busy    <= 1'b1;
                if (state_q == ST_SETUP || state_q == ST_RUN) begin
                    // Cut event: show its count now, clear it next cycle.
                    bx_done   <= 1'b1;
                    truncated <= 1'b1;
                    mismatch  <= (wc_d != expected);
                    wc_q      <= wc_d;
                    clr_q     <= 1'b1;
                end else begin
                    wc_q <= '0;
                end
            end else begin
                if (clr_q) begin
                    wc_q <= '0;
                end
                unique case (state_q)
                    ST_IDLE: begin
                        busy <= 1'b0;
                    end
                    ST_SETUP: begin
                        if (setup_q == 8'(SETUP_CYC)) begin
                            state_q <= ST_RUN;
                            flush_q <= '0;
                        end else begin
                            setup_q <= setup_q + 8'd1;
                        end
                    end
                    ST_RUN: begin
                        wc_q <= wc_d;
                        if (none) begin
                            // Second none covers the merger's registered valid.
                            if (flush_q == 2'd1) begin
                                state_q  <= ST_DONE;
                                busy     <= 1'b0;
                                bx_done  <= 1'b1;
                                mismatch <= (wc_d != expected);
                                flush_q  <= '0;
                            end else begin
                                flush_q <= flush_q + 2'd1;
                            end
                        end else begin
                            flush_q <= '0;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_cnt = wc_q;

`ifdef READOUT_STATS_EN
    logic [15:0] trunc_q;
    logic [15:0] mism_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trunc_q <= '0;
            mism_q  <= '0;
        end else begin
            if (bx_done && truncated && !(&trunc_q)) begin
                trunc_q <= trunc_q + 16'd1;
            end
            if (bx_done && mismatch && !(&mism_q)) begin
                mism_q <= mism_q + 16'd1;
            end
        end
    end

    assign trunc_cnt = trunc_q;
    assign mism_cnt  = mism_q;
`else
    assign trunc_cnt = 16'h0000;
    assign mism_cnt  = 16'h0000;
`endif

endmodule
